regfile_mp: RTL and testbench

Parametrised multi-port register file for the CPU datapath, the successor to the single-write 16×16 register file. It provides two combinational read ports, two clocked write ports with fixed priority, optional write-to-read bypass and an optional hardwired-zero register 0. A per-register busy scoreboard lets issue logic stall on registers that still have a pending writeback.

---
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass, optional hardwired zero and busy scoreboard
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RegWre0,
  input  logic [ADDR_W-1:0] WAddr0,
  input  logic [DATA_W-1:0] WData0,
  input  logic              RegWre1,
  input  logic [ADDR_W-1:0] WAddr1,
  input  logic [DATA_W-1:0] WData1,
  input  logic [ADDR_W-1:0] RAddr1,
  input  logic [ADDR_W-1:0] RAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              MarkBusy,
  input  logic [ADDR_W-1:0] MarkAddr,
  output logic              Busy1,
  output logic              Busy2
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR = ZERO_REG != 0;
  localparam bit BP = BYPASS != 0;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              we0, we1, mark;

  // bypassed/zero-forced read of one address
  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    return (ZR && a == '0) ? '0 :
           (BP && RegWre1 && WAddr1 == a) ? WData1 :
           (BP && RegWre0 && WAddr0 == a) ? WData0 : regs_q[a];
  endfunction

  // busy of one address; a pending write hides it unless a mark to it is also pending
  function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
    return (ZR && a == '0) ? 1'b0 :
           (BP && ((RegWre1 && WAddr1 == a) || (RegWre0 && WAddr0 == a)) &&
            !(MarkBusy && MarkAddr == a)) ? 1'b0 : busy_q[a];
  endfunction

  // effective enables: register 0 swallows writes and marks when hardwired
  always_comb begin
    we0  = RegWre0 && !(ZR && WAddr0 == '0);
    we1  = RegWre1 && !(ZR && WAddr1 == '0);
    mark = MarkBusy && !(ZR && MarkAddr == '0);
  end

  // next state: port 1 overrides port 0, mark overrides the write-clear
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we0) begin
      regs_d[WAddr0] = WData0;
      busy_d[WAddr0] = 1'b0;
    end
    if (we1) begin
      regs_d[WAddr1] = WData1;
      busy_d[WAddr1] = 1'b0;
    end
    if (mark) busy_d[MarkAddr] = 1'b1;
  end

  // state registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // combinational read and busy ports
  always_comb begin
    ReadData1 = rd_data(RAddr1);
    ReadData2 = rd_data(RAddr2);
    Busy1     = rd_busy(RAddr1);
    Busy2     = rd_busy(RAddr2);
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: checks two configurations (zero+bypass, plain) against a reference model
module tb_regfile_mp;
  logic        CLK = 1'b0, RESET = 1'b0;
  logic        RegWre0 = 0, RegWre1 = 0, MarkBusy = 0;
  logic [3:0]  WAddr0 = 0, WAddr1 = 0, RAddr1 = 0, RAddr2 = 0, MarkAddr = 0;
  logic [15:0] WData0 = 0, WData1 = 0;
  logic [15:0] rd1 [2];
  logic [15:0] rd2 [2];
  logic        bz1 [2];
  logic        bz2 [2];
  int          nv = 0, nerr = 0;

  // model state: instance 0 = ZERO_REG 1 / BYPASS 1, instance 1 = ZERO_REG 0 / BYPASS 0
  logic [15:0] mem [2][16];
  logic        bsy [2][16];
  bit          zr [2] = '{1'b1, 1'b0};
  bit          bp [2] = '{1'b1, 1'b0};

  always #5 CLK = ~CLK;

  regfile_mp u_a (
    .CLK(CLK), .RESET(RESET), .RegWre0(RegWre0), .WAddr0(WAddr0), .WData0(WData0),
    .RegWre1(RegWre1), .WAddr1(WAddr1), .WData1(WData1), .RAddr1(RAddr1), .RAddr2(RAddr2),
    .ReadData1(rd1[0]), .ReadData2(rd2[0]), .MarkBusy(MarkBusy), .MarkAddr(MarkAddr),
    .Busy1(bz1[0]), .Busy2(bz2[0]));

  regfile_mp #(.ZERO_REG(0), .BYPASS(0)) u_b (
    .CLK(CLK), .RESET(RESET), .RegWre0(RegWre0), .WAddr0(WAddr0), .WData0(WData0),
    .RegWre1(RegWre1), .WAddr1(WAddr1), .WData1(WData1), .RAddr1(RAddr1), .RAddr2(RAddr2),
    .ReadData1(rd1[1]), .ReadData2(rd2[1]), .MarkBusy(MarkBusy), .MarkAddr(MarkAddr),
    .Busy1(bz1[1]), .Busy2(bz2[1]));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nv++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_rd(input int k, input logic [3:0] a);
    if (zr[k] && a == 0) return 16'h0;
    if (bp[k] && RegWre1 && WAddr1 == a) return WData1;
    if (bp[k] && RegWre0 && WAddr0 == a) return WData0;
    return mem[k][a];
  endfunction

  function automatic logic exp_bz(input int k, input logic [3:0] a);
    if (zr[k] && a == 0) return 1'b0;
    if (bp[k] && ((RegWre1 && WAddr1 == a) || (RegWre0 && WAddr0 == a)) &&
        !(MarkBusy && MarkAddr == a)) return 1'b0;
    return bsy[k][a];
  endfunction

  // reference model update
  always @(posedge CLK or negedge RESET) begin
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 16; r++) begin
        if (!RESET) begin
          mem[k][r] = 16'h0;
          bsy[k][r] = 1'b0;
        end else if (!(zr[k] && r == 0)) begin
          if (RegWre1 && WAddr1 == r) mem[k][r] = WData1;
          else if (RegWre0 && WAddr0 == r) mem[k][r] = WData0;
          if (MarkBusy && MarkAddr == r) bsy[k][r] = 1'b1;
          else if ((RegWre1 && WAddr1 == r) || (RegWre0 && WAddr0 == r)) bsy[k][r] = 1'b0;
        end
      end
  end

  // every-cycle compare against the model
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model rd1[%0d]", k), rd1[k], exp_rd(k, RAddr1));
      chk($sformatf("model rd2[%0d]", k), rd2[k], exp_rd(k, RAddr2));
      chk($sformatf("model bz1[%0d]", k), {15'h0, bz1[k]}, {15'h0, exp_bz(k, RAddr1)});
      chk($sformatf("model bz2[%0d]", k), {15'h0, bz2[k]}, {15'h0, exp_bz(k, RAddr2)});
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RegWre0 = 0; RegWre1 = 0; MarkBusy = 0;
  endtask

  initial begin
    #2;
    chk("reset rd1 a", rd1[0], 16'h0);
    chk("reset rd1 b", rd1[1], 16'h0);
    RESET = 1;
    for (int i = 1; i < 16; i++) begin
      cyc();
      RegWre0 = 1; WAddr0 = 4'(i); WData0 = 16'h1000 + 16'(i);
    end
    cyc(); idle(); MarkBusy = 1; MarkAddr = 2;
    cyc(); idle(); RAddr1 = 15; RAddr2 = 2; #1;
    chk("load r15 a", rd1[0], 16'h100F);
    chk("load r15 b", rd1[1], 16'h100F);
    chk("mark r2 b", {15'h0, bz2[1]}, 16'h1);
    RESET = 0; #1;
    chk("async reset rd a", rd1[0], 16'h0);
    chk("async reset rd b", rd1[1], 16'h0);
    chk("async reset busy a", {15'h0, bz2[0]}, 16'h0);
    chk("async reset busy b", {15'h0, bz2[1]}, 16'h0);
    RESET = 1;
    // write conflict on r5
    cyc(); RegWre0 = 1; WAddr0 = 5; WData0 = 16'h1111;
    RegWre1 = 1; WAddr1 = 5; WData1 = 16'h2222; RAddr1 = 5; #1;
    chk("conflict bypass a", rd1[0], 16'h2222);
    chk("conflict old b", rd1[1], 16'h0);
    cyc(); idle(); #1;
    chk("conflict stored a", rd1[0], 16'h2222);
    chk("conflict stored b", rd1[1], 16'h2222);
    cyc(); RegWre0 = 1; WAddr0 = 3; WData0 = 16'h3333;
    RegWre1 = 1; WAddr1 = 4; WData1 = 16'h4444;
    cyc(); idle(); RAddr1 = 3; RAddr2 = 4; #1;
    chk("dual r3 b", rd1[1], 16'h3333);
    chk("dual r4 b", rd2[1], 16'h4444);
    // same-cycle bypass on r7
    cyc(); RegWre1 = 1; WAddr1 = 7; WData1 = 16'hBEEF; RAddr1 = 7; #1;
    chk("bypass a", rd1[0], 16'hBEEF);
    chk("no bypass b", rd1[1], 16'h0);
    cyc(); idle(); #1;
    chk("after edge b", rd1[1], 16'hBEEF);
    // register 0
    cyc(); RegWre0 = 1; WAddr0 = 0; WData0 = 16'hFFFF; MarkBusy = 1; MarkAddr = 0;
    RAddr1 = 0; RAddr2 = 0;
    cyc(); idle(); #1;
    chk("zero rd a", rd1[0], 16'h0);
    chk("zero busy a", {15'h0, bz1[0]}, 16'h0);
    chk("r0 rd b", rd1[1], 16'hFFFF);
    chk("r0 busy b", {15'h0, bz1[1]}, 16'h1);
    // scoreboard on r9
    cyc(); MarkBusy = 1; MarkAddr = 9; RAddr1 = 9;
    cyc(); idle(); #1;
    chk("mark r9 a", {15'h0, bz1[0]}, 16'h1);
    chk("mark r9 b", {15'h0, bz1[1]}, 16'h1);
    cyc(); RegWre0 = 1; WAddr0 = 9; WData0 = 16'h0909; #1;
    chk("pending wr hides busy a", {15'h0, bz1[0]}, 16'h0);
    chk("pending wr keeps busy b", {15'h0, bz1[1]}, 16'h1);
    cyc(); idle(); #1;
    chk("clear r9 a", {15'h0, bz1[0]}, 16'h0);
    chk("clear r9 b", {15'h0, bz1[1]}, 16'h0);
    cyc(); RegWre1 = 1; WAddr1 = 9; WData1 = 16'h9999; MarkBusy = 1; MarkAddr = 9;
    cyc(); idle(); #1;
    chk("set wins a", {15'h0, bz1[0]}, 16'h1);
    chk("set wins b", {15'h0, bz1[1]}, 16'h1);
    chk("r9 data b", rd1[1], 16'h9999);
    // random traffic with occasional reset pulses
    for (int n = 0; n < 10000; n++) begin
      cyc();
      RegWre0 = 1'($urandom); WAddr0 = 4'($urandom); WData0 = 16'($urandom);
      RegWre1 = 1'($urandom); WAddr1 = ($urandom_range(0, 3) == 0) ? WAddr0 : 4'($urandom);
      WData1 = 16'($urandom);
      MarkBusy = 1'($urandom); MarkAddr = ($urandom_range(0, 3) == 0) ? WAddr0 : 4'($urandom);
      RAddr1 = ($urandom_range(0, 2) == 0) ? WAddr1 : 4'($urandom);
      RAddr2 = ($urandom_range(0, 2) == 0) ? MarkAddr : 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        RESET = 0; #2; RESET = 1;
      end
    end
    cyc(); idle();
    @(negedge CLK); #1;
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
